// File: rtl/izh_pkg.sv
// izh_pkg: shared constants and types for the spike event encoder.
//   V_W        membrane voltage width (signed 2.16 fixed point)
//   ISI_W      inter-spike interval counter / record width
//   FIFO_DEPTH event FIFO depth (power of two, >= 2)
//   THRESH     spike threshold (+0.30), REARM re-arm level (0.0)
//   BURST_ISI  burst-tag limit, only meaningful with BURST_TAG_EN
//   EW         record width: ISI_W, or ISI_W+1 when BURST_TAG_EN is defined
// Optional feature macro: BURST_TAG_EN
package izh_pkg;

  localparam int V_W        = 18;
  localparam int ISI_W      = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int BURST_ISI  = 4;

  localparam logic signed [V_W-1:0] THRESH = 18'sh0_4CCC;
  localparam logic signed [V_W-1:0] REARM  = 18'sh0_0000;

`ifdef BURST_TAG_EN
  localparam int EW = ISI_W + 1;
`else
  localparam int EW = ISI_W;
`endif

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    ARMED      = 2'd1,
    REFRACT    = 2'd2
  } det_state_t;

  typedef logic [EW-1:0] isi_rec_t;

endpackage

// File: rtl/spike_fifo.sv
// spike_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n  clock, async active-low reset
//   flush       synchronous empty (wins over push/pop)
//   push/wdata  write request and data
//   pop         read request, ignored while empty
//   rdata       head entry while non-empty, zero while empty
//   empty/full/level  occupancy status
// A push while full succeeds only if a pop frees the slot in the same cycle.
module spike_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: rdata is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spike_event_encoder.sv
// spike_event_encoder: threshold spike detector with hysteresis, ISI
// measurement in update steps, and an FWFT event FIFO of ISI records.
//   clk, rst_n        clock, async active-low reset
//   v_in, v_valid     signed 2.16 membrane voltage sample and its strobe
//   clear             synchronous soft clear (keeps spike_cnt, overflow)
//   spike_o           one-cycle pulse the cycle after a spiking sample
//   spike_cnt         wrapping spike total
//   rd_en, rd_data    FIFO pop and FWFT head
//   empty, full, level  FIFO status
//   overflow, clear_ovf sticky record-drop flag and its clear
// Optional feature macro: BURST_TAG_EN (adds a burst bit above the ISI).
//
// state      | meaning
// WAIT_FIRST | no spike yet, next spike's ISI is unknown (all-ones)
// ARMED      | below re-arm since last spike, next crossing spikes
// REFRACT    | just spiked, waiting for v_in < REARM
module spike_event_encoder
  import izh_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic signed [V_W-1:0] v_in,
  input  logic                  v_valid,
  input  logic                  clear,
  output logic                  spike_o,
  output logic [15:0]           spike_cnt,
  input  logic                  rd_en,
  output logic [EW-1:0]         rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [LVL_W-1:0]      level,
  output logic                  overflow,
  input  logic                  clear_ovf
);

  det_state_t       state;
  logic [ISI_W-1:0] isi_cnt;
  logic [ISI_W-1:0] isi_next;
  logic [ISI_W-1:0] isi_val;
  logic             above;
  logic             below;
  logic             spike_now;
  logic             drop;
  isi_rec_t         rec;

  assign above     = (v_in > THRESH);
  assign below     = (v_in < REARM);
  assign isi_next  = (isi_cnt == '1) ? isi_cnt : isi_cnt + 1'b1;
  assign spike_now = v_valid && above && (state != REFRACT);
  assign isi_val   = (state == WAIT_FIRST) ? '1 : isi_next;

`ifdef BURST_TAG_EN
  logic burst;
  assign burst = (state == ARMED) && (isi_next <= ISI_W'(BURST_ISI));
  assign rec   = {burst, isi_val};
`else
  assign rec   = isi_val;
`endif

  // Full implies non-empty, so rd_en alone tells whether a slot frees up.
  assign drop = spike_now && full && !rd_en && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_FIRST;
      isi_cnt   <= '0;
      spike_cnt <= '0;
      spike_o   <= 1'b0;
    end else if (clear) begin
      state     <= WAIT_FIRST;
      isi_cnt   <= '0;
      spike_o   <= 1'b0;
    end else begin
      spike_o <= spike_now;
      if (spike_now) spike_cnt <= spike_cnt + 1'b1;
      if (v_valid) begin
        isi_cnt <= spike_now ? '0 : isi_next;
        case (state)
          WAIT_FIRST: if (above) state <= REFRACT;
          ARMED:      if (above) state <= REFRACT;
          REFRACT:    if (below) state <= ARMED;
          default:    state <= WAIT_FIRST;
        endcase
      end
    end
  end

  // Set wins over a same-cycle clear_ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  spike_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (spike_now),
    .wdata (rec),
    .pop   (rd_en),
    .rdata (rd_data),
    .empty (empty),
    .full  (full),
    .level (level)
  );

endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
- Downstream consumer of the Izhikevich neuron core.
- Samples the signed 2.16 membrane voltage once per neuron update step.
- Detects threshold-crossing spikes with hysteresis and measures the inter-spike interval (ISI) in update steps.
- Pushes one ISI record per spike into a small first-word-fall-through (FWFT) FIFO, which the top-level readout logic drains.

Parameters:
- V_W, 18, membrane voltage width (signed 2.16 fixed point).
- ISI_W, 16, ISI counter and record width; saturating.
- FIFO_DEPTH, 8, event FIFO depth; power of two, at least 2.
- THRESH, 18'sh0_4CCC, spike threshold (+0.30).
- REARM, 18'sh0_0000, re-arm level (0.0); must be less than THRESH.
- BURST_ISI, 4, burst-tag limit; used only with the optional feature.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- v_in, input, V_W, signed membrane voltage from the neuron core.
- v_valid, input, 1, v_in holds a new update-step sample this cycle.
- clear, input, 1, synchronous soft clear.
- spike_o, output, 1, one-cycle spike pulse.
- spike_cnt, output, 16, total spikes detected; wraps.
- rd_en, input, 1, pop FIFO head.
- rd_data, output, EW, FIFO head. EW = ISI_W, or ISI_W+1 with BURST_TAG_EN.
- empty, output, 1, FIFO empty.
- full, output, 1, FIFO full.
- level, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
- overflow, output, 1, sticky: a record was dropped.
- clear_ovf, input, 1, clears overflow.

Behaviour:
- Reset (async, rst_n=0):
  - state=WAIT_FIRST, isi_cnt=0, spike_cnt=0, spike_o=0, overflow=0.
  - FIFO emptied: empty=1, full=0, level=0, rd_data=0.
- Comparisons are signed over all V_W bits. Only cycles with v_valid=1 are samples; all other cycles leave state and counters unchanged.
- isi_cnt:
  - On each sample: next = sat(isi_cnt+1), saturating at 2^ISI_W-1.
  - On a spiking sample the record value is sat(isi_cnt+1) and isi_cnt is set to 0.
  - ISI therefore equals the number of samples from the previous spike sample to the current one.
- States:
  - WAIT_FIRST: sample with v_in > THRESH → spike; record = all-ones (ISI unknown); go to REFRACT.
  - ARMED: sample with v_in > THRESH → spike with measured ISI; go to REFRACT.
  - REFRACT: samples above THRESH are ignored. A sample with v_in < REARM (strict) goes to ARMED; that sample cannot itself spike.
  - v_in == THRESH is not a spike. v_in == REARM does not re-arm.
- Spike outputs: spike_o is registered and pulses exactly one cycle, the cycle after the spiking sample. spike_cnt increments at the same time.
- FIFO:
  - FWFT: rd_data is the head entry whenever empty=0.
  - Pop on rd_en && !empty. rd_en while empty is ignored and causes no underflow.
  - Push and pop in the same cycle: level unchanged. When full, the pop frees the slot and the push succeeds.
  - Push while full without a pop: record dropped, overflow set.
  - The record becomes visible at rd_data one cycle after the spiking sample.
- overflow clears on clear_ovf. If a drop and clear_ovf happen in the same cycle, set wins.
- clear (synchronous):
  - Equivalent to reset except spike_cnt and overflow are kept.
  - Overrides a same-cycle sample, spike and rd_en.
- Reset asserted mid-stream loses all FIFO contents; no partial record survives.

Optional Feature:
- Macro: BURST_TAG_EN.
- Defined:
  - Each record = {burst, isi}, EW = ISI_W+1.
  - burst=1 when the record is from state ARMED and isi <= BURST_ISI.
  - WAIT_FIRST records always have burst=0.
- Undefined: record = isi only, EW = ISI_W; BURST_ISI is unused.

Decomposition:
- Package izh_pkg:
  - V_W and the 2.16 constants (THRESH default 18'sh0_4CCC, REARM default 18'sh0_0000).
  - Spike-detector state enum: WAIT_FIRST, ARMED, REFRACT.
  - ISI record typedef.
- Sub-module spike_fifo:
  - Synchronous FWFT FIFO, parameterized on width and depth.
  - Provides level, full, empty, and simultaneous push/pop.
  - Async active-low reset plus a synchronous flush input.

Test Plan:
- Basic spike: after reset, one sample v_in=18'sh0_8000 → spike_o pulse on the next cycle, rd_data=16'hFFFF, level=1, spike_cnt=1.
- ISI measurement: spike, 4 samples at 18'sh3_0000 (negative, re-arms), 1 sample at 18'sh0_8000 → second record=5; samples with v_valid=0 in between do not change it.
- Hysteresis and equality: v_in=THRESH exactly → no spike. Above THRESH twice without dropping below REARM → one spike only. A sample equal to REARM does not re-arm.
- Saturation: after the first spike, 70000 samples below threshold then a spike → record=16'hFFFF.
- FIFO boundaries:
  - 9 spikes without reads → full=1, overflow=1, first 8 records intact.
  - Spike with rd_en while full → level stays 8, new record accepted.
  - rd_en while empty → no change.
- Clear and reset: assert clear mid-stream → FIFO empty, state WAIT_FIRST, spike_cnt kept. Assert rst_n=0 asynchronously between clock edges → all outputs at reset values immediately. With BURST_TAG_EN defined, ISI=3 → burst bit=1.
